// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register in-flight write counters, load-use and saturation stall.
// Optional multiply/divide tracking FSM enabled by defining SCOREBOARD_MULDIV_EN.
module reg_scoreboard (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid_i,
  input  logic        issue_we_i,
  input  logic [4:0]  issue_rd_i,
  input  logic        issue_is_load_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic        flush_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_rs1_used_i,
  input  logic        id_rs2_used_i,
`ifdef SCOREBOARD_MULDIV_EN
  input  logic        issue_is_muldiv_i,
  input  logic        muldiv_done_i,
  output logic        muldiv_busy_o,
`endif
  output logic        stall_o,
  output logic [31:0] busy_o,
  output logic        err_o
);

  logic [1:0]  cnt_q [32];
  logic [1:0]  cnt_d [32];
  logic [31:0] lp_q, lp_d;
  logic        err_q, err_d;

  logic load_use, sat_stall, md_stall, md_err, accept;
  logic inc, dec;

  always_comb begin
    load_use  = (id_rs1_used_i && lp_q[id_rs1_i]) || (id_rs2_used_i && lp_q[id_rs2_i]);
    sat_stall = issue_valid_i && issue_we_i && (cnt_q[issue_rd_i] == 2'd3);
    stall_o   = load_use || sat_stall || md_stall;
    accept    = issue_valid_i && issue_we_i && (issue_rd_i != 5'd0) && !stall_o;
  end

`ifdef SCOREBOARD_MULDIV_EN
  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;
  md_state_e  md_state_q, md_state_d;
  logic [4:0] md_rd_q, md_rd_d;

  always_comb begin
    md_stall = (md_state_q == MD_BUSY) &&
               ((id_rs1_used_i && (id_rs1_i == md_rd_q)) ||
                (id_rs2_used_i && (id_rs2_i == md_rd_q)) ||
                issue_is_muldiv_i);
  end

  always_comb begin
    md_state_d    = md_state_q;
    md_rd_d       = md_rd_q;
    md_err        = 1'b0;
    muldiv_busy_o = (md_state_q == MD_BUSY);
    case (md_state_q)
      MD_IDLE: begin
        if (muldiv_done_i) md_err = 1'b1;
        if (accept && issue_is_muldiv_i) begin
          md_state_d = MD_BUSY;
          md_rd_d    = issue_rd_i;
        end
      end
      MD_BUSY: if (muldiv_done_i) md_state_d = MD_IDLE;
      default: md_state_d = MD_IDLE;
    endcase
    if (flush_i) md_state_d = MD_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_state_q <= MD_IDLE;
      md_rd_q    <= '0;
    end else begin
      md_state_q <= md_state_d;
      md_rd_q    <= md_rd_d;
    end
  end
`else
  assign md_stall = 1'b0;
  assign md_err   = 1'b0;
`endif

  always_comb begin
    cnt_d = cnt_q;
    lp_d  = lp_q;
    err_d = err_q;
    inc   = 1'b0;
    dec   = 1'b0;
    for (int unsigned n = 1; n < 32; n++) begin
      inc = accept && (issue_rd_i == 5'(n));
      dec = wb_valid_i && (wb_rd_i == 5'(n));
      // A matched issue and writeback cancel; neither can overflow nor underflow then.
      if (inc && !dec) begin
        if (cnt_q[n] == 2'd3) err_d = 1'b1;
        else                  cnt_d[n] = cnt_q[n] + 2'd1;
      end else if (dec && !inc) begin
        if (cnt_q[n] == 2'd0) err_d = 1'b1;
        else                  cnt_d[n] = cnt_q[n] - 2'd1;
      end
      if (inc)                    lp_d[n] = issue_is_load_i;
      else if (cnt_d[n] == 2'd0)  lp_d[n] = 1'b0;
    end
    cnt_d[0] = '0;
    lp_d[0]  = 1'b0;
    if (flush_i) begin
      for (int unsigned n = 0; n < 32; n++) cnt_d[n] = '0;
      lp_d  = '0;
      err_d = err_q;
    end
    err_d = err_d || md_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned n = 0; n < 32; n++) cnt_q[n] <= '0;
      lp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      for (int unsigned n = 0; n < 32; n++) cnt_q[n] <= cnt_d[n];
      lp_q  <= lp_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    busy_o = '0;
    for (int unsigned n = 1; n < 32; n++) busy_o[n] = (cnt_q[n] != 2'd0);
  end

  assign err_o = err_q;

endmodule
